// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with credit-limited, in-order requests to a
// variable-latency instruction memory and a DEPTH-entry output FIFO ahead of decode.
// Redirects flush the FIFO and discard every response still owed.
// Optional build macro IFU_ALIGN_EXC_EN: misaligned redirect targets produce a single
// exception entry (out_exc=1) instead of a fetch; otherwise redirect_pc[1:0] is ignored.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
`ifdef IFU_ALIGN_EXC_EN
    output logic             out_exc,
`endif
    output logic [CNT_W-1:0] fifo_count
);

    localparam int             AW  = $clog2(DEPTH);
    localparam logic [CNT_W:0] LIM = (CNT_W+1)'(DEPTH);

    // r_outstanding counts every response still owed, including ones to be dropped;
    // r_drop_cnt is the subset of those that must be discarded.
    logic [31:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_idle;
    logic [AW-1:0]    r_pcq_wr, r_pcq_rd;
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [31:0]      r_pcq        [DEPTH];
    logic [31:0]      r_fifo_instr [DEPTH];
    logic [31:0]      r_fifo_pc    [DEPTH];

    logic [31:0]      w_redir_pc;
    logic             w_misalign;
    logic [CNT_W:0]   w_inflight;
    logic             w_credit;
    logic             w_accept;
    logic             w_rsp;
    logic             w_keep;
    logic             w_pop;
    logic             w_fifo_wr;
    logic [AW-1:0]    w_wr_idx;
    logic [31:0]      w_wr_instr;
    logic [31:0]      w_wr_pc;

`ifdef IFU_ALIGN_EXC_EN
    logic             r_fifo_exc [DEPTH];
    assign w_redir_pc = redirect_pc;
    assign w_misalign = (redirect_pc[1:0] != 2'b00);
`else
    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_misalign = 1'b0;
`endif

    // Every request issued must have a FIFO slot reserved for its response.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit   = (w_inflight < LIM);
    assign imem_req   = !reset && !redirect_valid && (r_drop_cnt == '0) && !r_idle && w_credit;
    assign imem_addr  = r_fetch_pc;

    // A response with nothing owed is ignored entirely.
    assign w_accept   = imem_req && imem_gnt;
    assign w_rsp      = imem_rvalid && (r_outstanding != '0);
    assign w_keep     = w_rsp && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop      = out_valid && out_ready;

    // A misaligned redirect writes its exception entry into slot 0 of the flushed FIFO.
    assign w_fifo_wr  = w_keep || (redirect_valid && w_misalign);
    assign w_wr_idx   = redirect_valid ? '0 : r_wr_ptr;
    assign w_wr_instr = redirect_valid ? 32'h0 : imem_rdata;
    assign w_wr_pc    = redirect_valid ? redirect_pc : r_pcq[r_pcq_rd];

    // Fetch PC, owed-response bookkeeping and the post-exception idle flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_idle        <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= w_redir_pc;
            r_idle        <= w_misalign;
            r_outstanding <= r_outstanding - CNT_W'(w_rsp);
            r_drop_cnt    <= r_outstanding - CNT_W'(w_rsp);
        end else begin
            if (w_accept)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);
            if (w_rsp && (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        end
    end

    // PC queue and FIFO pointers; a redirect empties both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
            r_wr_ptr <= AW'(w_misalign);
            r_rd_ptr <= '0;
            r_count  <= CNT_W'(w_misalign);
        end else begin
            r_pcq_wr <= r_pcq_wr + AW'(w_accept);
            r_pcq_rd <= r_pcq_rd + AW'(w_keep);
            r_wr_ptr <= r_wr_ptr + AW'(w_keep);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CNT_W'(w_keep) - CNT_W'(w_pop);
        end
    end

    // Storage arrays need no reset: validity is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        if (w_fifo_wr) begin
            r_fifo_instr[w_wr_idx] <= w_wr_instr;
            r_fifo_pc[w_wr_idx]    <= w_wr_pc;
`ifdef IFU_ALIGN_EXC_EN
            r_fifo_exc[w_wr_idx]   <= redirect_valid;
`endif
        end
    end

    // Head outputs read zero whenever the FIFO is empty.
    assign out_valid  = (r_count != '0);
    assign out_instr  = out_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
    assign out_pc     = out_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;
    assign fifo_count = r_count;
`ifdef IFU_ALIGN_EXC_EN
    assign out_exc    = out_valid ? r_fifo_exc[r_rd_ptr] : 1'b0;
`endif

    // Memory must never return a word that was not requested.
    assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && (r_outstanding == '0)))
        else $error("ifu_prefetch: imem_rvalid with no outstanding request");

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed scenarios plus a randomized run
// compared against a queue-based reference model (epoch-tagged memory responses).
module tb_ifu_prefetch;
    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [31:0]      imem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc;
`ifdef IFU_ALIGN_EXC_EN
    logic             out_exc;
`endif
    logic [CNT_W-1:0] fifo_count;

    ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
`ifdef IFU_ALIGN_EXC_EN
        .out_exc(out_exc),
`endif
        .fifo_count(fifo_count)
    );

    typedef struct { int due; int epoch; logic [31:0] pc; logic [31:0] data; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic exc; } ent_t;

    rsp_t        rspq[$];
    ent_t        fifoq[$];
    int          cyc = 0, last_due = 0, m_epoch = 0, lat = 1;
    logic [31:0] m_pc;
    logic        m_idle;
    logic        d_redir, d_rdy, d_gnt;
    logic [31:0] d_rpc;
    logic        s_req, s_valid, s_exc;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [CNT_W-1:0] s_cnt, e_cnt;
    logic        e_req, e_valid, e_exc;
    logic [31:0] e_addr, e_pc, e_instr;
    int          checks = 0, failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (rspq[i]) if (rspq[i].epoch != m_epoch) n++;
        return n;
    endfunction

    // One clock: drive at negedge, sample before posedge, advance model after posedge.
    task automatic tick();
        rsp_t r;
        ent_t e;
        bit rv, pop, kept;
        @(negedge clk);
        redirect_valid = d_redir;
        redirect_pc    = d_rpc;
        out_ready      = d_rdy;
        imem_gnt       = d_gnt;
        rv = (rspq.size() > 0) && (rspq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? rspq[0].data : $urandom;
        e_req   = !d_redir && !m_idle && (stale_cnt() == 0) && (rspq.size() + fifoq.size() < DEPTH);
        e_addr  = m_pc;
        e_valid = (fifoq.size() > 0);
        e_pc    = e_valid ? fifoq[0].pc    : 32'h0;
        e_instr = e_valid ? fifoq[0].instr : 32'h0;
        e_exc   = e_valid ? fifoq[0].exc   : 1'b0;
        e_cnt   = CNT_W'(fifoq.size());
        #2;
        s_req = imem_req; s_addr = imem_addr; s_valid = out_valid;
        s_pc = out_pc; s_instr = out_instr; s_cnt = fifo_count;
`ifdef IFU_ALIGN_EXC_EN
        s_exc = out_exc;
`else
        s_exc = 1'b0;
`endif
        @(posedge clk);
        pop  = e_valid && d_rdy;
        kept = 1'b0;
        if (rv) begin
            r = rspq.pop_front();
            kept = (r.epoch == m_epoch) && !d_redir;
        end
        if (d_redir) begin
            fifoq.delete();
            m_epoch++;
`ifdef IFU_ALIGN_EXC_EN
            if (d_rpc[1:0] != 2'b00) begin
                e.pc = d_rpc; e.instr = 32'h0; e.exc = 1'b1;
                fifoq.push_back(e);
                m_idle = 1'b1;
            end else begin
                m_idle = 1'b0;
                m_pc = d_rpc;
            end
`else
            m_idle = 1'b0;
            m_pc = {d_rpc[31:2], 2'b00};
`endif
        end else begin
            if (pop) fifoq.delete(0);
            if (kept) begin
                e.pc = r.pc; e.instr = r.data; e.exc = 1'b0;
                fifoq.push_back(e);
            end
        end
        if (s_req && d_gnt) begin
            r.due = cyc + lat;
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            r.epoch = m_epoch; r.pc = m_pc; r.data = mem_word(s_addr);
            rspq.push_back(r);
            m_pc = m_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
        d_redir = 1'b0; d_rpc = 32'h0; d_rdy = 1'b0; d_gnt = 1'b0; lat = 1;
        rspq.delete(); fifoq.delete();
        m_epoch = 0; m_pc = RESET_PC; m_idle = 1'b0; last_due = cyc;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        apply_reset();
        #2;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL post_reset_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL post_reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        int max_cnt = 0;
        logic [31:0] pc;
        apply_reset();
        d_gnt = 1'b1; d_rdy = 1'b1; lat = 1;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (int'(s_cnt) > max_cnt) max_cnt = int'(s_cnt);
            if (k >= 2) begin
                pc = RESET_PC + 32'(4 * (k - 2));
                checks++;
                if (s_valid !== 1'b1 || s_pc !== pc || s_instr !== mem_word(pc)) begin
                    failures++;
                    $display("FAIL stream_k%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                             k, s_valid, s_pc, s_instr, pc, mem_word(pc));
                end
            end
        end
        checks++; if (max_cnt > 1) begin failures++; $display("FAIL stream_max_count got=%0d exp<=1", max_cnt); end
    endtask

    task automatic test_backpressure();
        int nreq = 0, npop = 0;
        logic [31:0] pc;
        apply_reset();
        d_gnt = 1'b1; d_rdy = 1'b0; lat = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_req) nreq++;
        end
        checks++; if (nreq != 4) begin failures++; $display("FAIL bp_requests got=%0d exp=4", nreq); end
        checks++; if (s_cnt !== CNT_W'(4)) begin failures++; $display("FAIL bp_count got=%0d exp=4", s_cnt); end
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL bp_req_held got=%b exp=0", s_req); end
        checks++; if (s_pc !== RESET_PC) begin failures++; $display("FAIL bp_head_stable got=%h exp=%h", s_pc, RESET_PC); end
        d_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            pc = RESET_PC + 32'(4 * k);
            checks++;
            if (s_valid !== 1'b1 || s_pc !== pc || s_instr !== mem_word(pc)) begin
                failures++;
                $display("FAIL bp_pop%0d got v=%b pc=%h exp pc=%h", k, s_valid, s_pc, pc);
            end
            if (s_valid) npop++;
        end
        checks++; if (npop != 4) begin failures++; $display("FAIL bp_pop_count got=%0d exp=4", npop); end
    endtask

    // Wait (bounded) for the first head entry and check it, optionally at an exact tick.
    task automatic first_head(input string nm, input logic [31:0] pc, input int t0, input int t_exp);
        bit found = 0;
        for (int t = t0; t < t0 + 30 && !found; t++) begin
            tick();
            if (s_valid) begin
                found = 1;
                checks++;
                if (s_pc !== pc || s_instr !== mem_word(pc)) begin
                    failures++;
                    $display("FAIL %s_first got pc=%h instr=%h exp pc=%h instr=%h", nm, s_pc, s_instr, pc, mem_word(pc));
                end
                if (t_exp >= 0) begin
                    checks++;
                    if (t != t_exp) begin failures++; $display("FAIL %s_first_cycle got=%0d exp=%0d", nm, t, t_exp); end
                end
            end
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL %s_timeout got=no_valid exp=pc %h", nm, pc);
        end
    endtask

    task automatic test_redirect_drop();
        apply_reset();
        d_gnt = 1'b1; d_rdy = 1'b1; lat = 4;
        repeat (3) tick();
        d_redir = 1'b1; d_rpc = 32'h0000_3100; tick(); d_redir = 1'b0;
        for (int t = 4; t <= 6; t++) begin
            tick();
            checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL drop_noreq_t%0d got=%b exp=0", t, s_req); end
        end
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h3100) begin
            failures++; $display("FAIL drop_resume got req=%b addr=%h exp req=1 addr=00003100", s_req, s_addr);
        end
        first_head("drop", 32'h0000_3100, 8, 12);
    endtask

    task automatic test_redirect_collide();
        apply_reset();
        d_gnt = 1'b1; d_rdy = 1'b1; lat = 2;
        repeat (3) tick();
        d_redir = 1'b1; d_rpc = 32'h0000_3200; tick(); d_redir = 1'b0;
        checks++; if (s_valid !== 1'b1 || s_pc !== RESET_PC) begin
            failures++; $display("FAIL collide_pop got v=%b pc=%h exp v=1 pc=%h", s_valid, s_pc, RESET_PC);
        end
        tick();
        checks++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin
            failures++; $display("FAIL collide_flush got v=%b req=%b exp v=0 req=0", s_valid, s_req);
        end
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h3200) begin
            failures++; $display("FAIL collide_resume got req=%b addr=%h exp req=1 addr=00003200", s_req, s_addr);
        end
        first_head("collide", 32'h0000_3200, 6, 8);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        d_gnt = 1'b1; d_rdy = 1'b1; lat = 4;
        repeat (3) tick();
        d_redir = 1'b1; d_rpc = 32'h0000_3400; tick();
        d_rpc = 32'h0000_3500; tick(); d_redir = 1'b0;
        for (int t = 5; t <= 6; t++) begin
            tick();
            checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL b2b_noreq_t%0d got=%b exp=0", t, s_req); end
        end
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h3500) begin
            failures++; $display("FAIL b2b_resume got req=%b addr=%h exp req=1 addr=00003500", s_req, s_addr);
        end
        first_head("b2b", 32'h0000_3500, 8, 12);
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        d_gnt = 1'b1; d_rdy = 1'b0; lat = 2;
        repeat (3) tick();
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
            failures++; $display("FAIL mid_pre got v=%b pc=%h exp v=1 pc=%h", out_valid, out_pc, RESET_PC);
        end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || fifo_count !== '0) begin
            failures++; $display("FAIL mid_async got req=%b v=%b instr=%h pc=%h cnt=%0d exp all 0",
                                 imem_req, out_valid, out_instr, out_pc, fifo_count);
        end
        apply_reset();
        d_gnt = 1'b1; d_rdy = 1'b1; lat = 1;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
            failures++; $display("FAIL mid_restart got req=%b addr=%h exp req=1 addr=%h", s_req, s_addr, RESET_PC);
        end
        first_head("mid", RESET_PC, 1, 2);
    endtask

    task automatic test_align();
        apply_reset();
        d_gnt = 1'b0; d_rdy = 1'b0; lat = 1;
        d_redir = 1'b1; d_rpc = 32'h0000_3102; tick(); d_redir = 1'b0;
        d_gnt = 1'b1;
`ifdef IFU_ALIGN_EXC_EN
        tick();
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h3102 || s_instr !== 32'h0 || s_exc !== 1'b1) begin
            failures++; $display("FAIL align_exc_entry got v=%b pc=%h instr=%h exc=%b exp v=1 pc=00003102 instr=0 exc=1",
                                 s_valid, s_pc, s_instr, s_exc);
        end
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++; if (s_req !== 1'b0 || s_cnt !== CNT_W'(1)) begin
                failures++; $display("FAIL align_idle_t%0d got req=%b cnt=%0d exp req=0 cnt=1", t, s_req, s_cnt);
            end
        end
        d_redir = 1'b1; d_rpc = 32'h0000_3100; tick(); d_redir = 1'b0;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h3100 || s_valid !== 1'b0) begin
            failures++; $display("FAIL align_resume got req=%b addr=%h v=%b exp req=1 addr=00003100 v=0", s_req, s_addr, s_valid);
        end
`else
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h3100) begin
            failures++; $display("FAIL align_forced got req=%b addr=%h exp req=1 addr=00003100", s_req, s_addr);
        end
        first_head("align", 32'h0000_3100, 2, 3);
`endif
    endtask

    task automatic test_random();
        int pops = 0;
        apply_reset();
        for (int n = 0; n < 2500; n++) begin
            d_gnt = ($urandom % 10) < 7;
            d_rdy = ($urandom % 10) < 7;
            lat   = $urandom_range(1, 5);
            d_redir = ($urandom % 20) == 0;
            if (d_redir) begin
                d_rpc = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
                if (($urandom % 4) != 0) d_rpc[1:0] = 2'b00;
            end
            tick();
            if (s_valid && d_rdy) pops++;
            checks++; if (s_req !== e_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, s_req, e_req); end
            if (e_req) begin
                checks++; if (s_addr !== e_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, s_addr, e_addr); end
            end
            checks++; if (s_valid !== e_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
            if (e_valid) begin
                checks++; if (s_pc !== e_pc || s_instr !== e_instr || s_exc !== e_exc) begin
                    failures++; $display("FAIL rnd_head cyc=%0d got pc=%h instr=%h exc=%b exp pc=%h instr=%h exc=%b",
                                         cyc, s_pc, s_instr, s_exc, e_pc, e_instr, e_exc);
                end
            end
            checks++; if (s_cnt !== e_cnt) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, s_cnt, e_cnt); end
        end
        checks++; if (pops < 100) begin failures++; $display("FAIL rnd_progress got=%0d pops exp>=100", pops); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "tb_ifu_prefetch watchdog expired");
    end

    initial begin
        d_redir = 1'b0; d_rpc = 32'h0; d_rdy = 1'b0; d_gnt = 1'b0;
        m_pc = RESET_PC; m_idle = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_back_to_back();
        test_reset_midburst();
        test_align();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
